// File: rtl/vote_recorder.sv
// Vote recorder: arms on a ballot pulse, records one one-hot candidate vote, then locks out.
// Optional build macro VOTE_REC_SAT_EN: counters saturate and drive a sticky sat_flag.
module vote_recorder #(
    parameter int unsigned NUM_CAND    = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned SEL_W       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ballot_en,
    input  logic [NUM_CAND-1:0] cand_pulse,
    input  logic                mode,
    input  logic [SEL_W-1:0]    result_sel,
    output logic                armed,
    output logic                vote_ok,
    output logic                invalid,
    output logic [CNT_W-1:0]    count_out,
    output logic                sat_flag
);

    localparam int unsigned LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CAND];
    logic [CNT_W-1:0]   cnt_d [NUM_CAND];
    logic               vote_ok_q, vote_ok_d;
    logic               invalid_q, invalid_d;
    logic [CNT_W-1:0]   cout_q, cout_d;
    logic               accept;
    logic               any_hit;
    logic               multi_hit;
    logic [CNT_W-1:0]   rd_val;

    // x & (x-1) is non-zero exactly when more than one bit is set
    assign any_hit   = |cand_pulse;
    assign multi_hit = |(cand_pulse & (cand_pulse - NUM_CAND'(1)));

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        accept    = 1'b0;
        invalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ballot_en && !mode) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (mode) begin
                    state_d = IDLE;
                end else if (multi_hit) begin
                    invalid_d = 1'b1;
                end else if (any_hit) begin
                    accept  = 1'b1;
                    state_d = LOCK;
                    lock_d  = LCK_W'(LOCK_CYCLES - 1);
                end
            end
            LOCK: begin
                if (lock_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q - LCK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        vote_ok_d = accept;
    end

`ifdef VOTE_REC_SAT_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && cand_pulse[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (cnt_d[i] == CNT_MAX) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && cand_pulse[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign sat_flag = 1'b0;
`endif

    // Out-of-range selects match no counter and read back as zero
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (32'(result_sel) == i) begin
                rd_val = cnt_q[i];
            end
        end
        cout_d = mode ? rd_val : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lock_q    <= '0;
            vote_ok_q <= 1'b0;
            invalid_q <= 1'b0;
            cout_q    <= '0;
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            vote_ok_q <= vote_ok_d;
            invalid_q <= invalid_d;
            cout_q    <= cout_d;
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign armed     = (state_q == ARMED);
    assign vote_ok   = vote_ok_q;
    assign invalid   = invalid_q;
    assign count_out = cout_q;

endmodule

// File: tb/tb_vote_recorder.sv
// Bench for vote_recorder: vector table, directed corner sequences and random traffic vs a ballot model.
// Two instances: default sizing and a small one (3 candidates, 2-bit counters, 3-cycle lockout).
module tb_vote_recorder;

`ifdef VOTE_REC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_in  [2];
    logic        ben_in  [2];
    logic        mode_in [2];
    logic [1:0]  sel_in  [2];
    logic [15:0] cand_in [2];

    logic       a0, v0, i0, s0;
    logic [7:0] c0;
    logic       a1, v1, i1, s1;
    logic [1:0] c1;

    vote_recorder #(.NUM_CAND(4), .CNT_W(8), .LOCK_CYCLES(16), .SEL_W(2)) u_dut (
        .clk(clk), .reset(rst_in[0]), .ballot_en(ben_in[0]), .cand_pulse(cand_in[0][3:0]),
        .mode(mode_in[0]), .result_sel(sel_in[0]), .armed(a0), .vote_ok(v0),
        .invalid(i0), .count_out(c0), .sat_flag(s0)
    );

    vote_recorder #(.NUM_CAND(3), .CNT_W(2), .LOCK_CYCLES(3), .SEL_W(2)) u_dut2 (
        .clk(clk), .reset(rst_in[1]), .ballot_en(ben_in[1]), .cand_pulse(cand_in[1][2:0]),
        .mode(mode_in[1]), .result_sel(sel_in[1]), .armed(a1), .vote_ok(v1),
        .invalid(i1), .count_out(c1), .sat_flag(s1)
    );

    int unsigned P_N [2] = '{4, 3};
    int unsigned P_W [2] = '{8, 2};
    int unsigned P_L [2] = '{16, 3};

    // Ballot model: open ballot flag, remaining lockout cycles, plain integer tallies
    bit          m_open [2];
    int unsigned m_lock [2];
    int unsigned m_cnt  [2][16];
    bit          m_sat  [2];
    bit          e_armed [2];
    bit          e_vote  [2];
    bit          e_inv   [2];
    int unsigned e_cout  [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(int d);
        int unsigned maxv;
        int unsigned ones;
        logic [15:0] c;
        maxv = (1 << P_W[d]) - 1;
        c    = cand_in[d] & 16'((1 << P_N[d]) - 1);
        ones = $countones(c);
        if (rst_in[d]) begin
            m_open[d] = 0; m_lock[d] = 0; m_sat[d] = 0;
            for (int k = 0; k < 16; k++) m_cnt[d][k] = 0;
            e_vote[d] = 0; e_inv[d] = 0; e_cout[d] = 0;
        end else begin
            e_cout[d] = (mode_in[d] && sel_in[d] < P_N[d]) ? m_cnt[d][sel_in[d]] : 0;
            e_vote[d] = 0;
            e_inv[d]  = 0;
            if (m_lock[d] > 0) begin
                m_lock[d]--;
            end else if (m_open[d]) begin
                if (mode_in[d]) begin
                    m_open[d] = 0;
                end else if (ones == 1) begin
                    for (int k = 0; k < int'(P_N[d]); k++) begin
                        if (c[k]) begin
                            if (SAT_EN && m_cnt[d][k] == maxv) m_cnt[d][k] = maxv;
                            else m_cnt[d][k] = (m_cnt[d][k] + 1) % (maxv + 1);
                            if (SAT_EN && m_cnt[d][k] == maxv) m_sat[d] = 1;
                        end
                    end
                    e_vote[d] = 1;
                    m_open[d] = 0;
                    m_lock[d] = P_L[d];
                end else if (ones > 1) begin
                    e_inv[d] = 1;
                end
            end else if (ben_in[d] && !mode_in[d]) begin
                m_open[d] = 1;
            end
        end
        e_armed[d] = m_open[d];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("armed0", a0, e_armed[0]);
        chk("vote_ok0", v0, e_vote[0]);
        chk("invalid0", i0, e_inv[0]);
        chk("count_out0", c0, e_cout[0]);
        chk("sat_flag0", s0, m_sat[0]);
        chk("armed1", a1, e_armed[1]);
        chk("vote_ok1", v1, e_vote[1]);
        chk("invalid1", i1, e_inv[1]);
        chk("count_out1", c1, e_cout[1]);
        chk("sat_flag1", s1, m_sat[1]);
    endtask

    task automatic drv(int d, bit r, bit b, logic [15:0] c, bit m, logic [1:0] s);
        rst_in[d] = r; ben_in[d] = b; cand_in[d] = c; mode_in[d] = m; sel_in[d] = s;
    endtask

    task automatic vote(int d, int idx);
        drv(d, 0, 1, 0, 0, 0);
        tick();
        drv(d, 0, 0, 16'(1) << idx, 0, 0);
        tick();
        drv(d, 0, 0, 0, 0, 0);
        repeat (P_L[d]) tick();
    endtask

    typedef struct {
        bit         r, b;
        logic [3:0] c;
        bit         m;
        logic [1:0] s;
        bit         ea, ev, ei;
        logic [7:0] ec;
    } vec_t;

    function automatic vec_t mk(bit r, bit b, logic [3:0] c, bit m, logic [1:0] s,
                                bit ea, bit ev, bit ei, logic [7:0] ec);
        vec_t v;
        v.r = r; v.b = b; v.c = c; v.m = m; v.s = s;
        v.ea = ea; v.ev = ev; v.ei = ei; v.ec = ec;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Expected outputs are those seen just after the edge that samples each row
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0100, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 2, 0, 0, 0, 0));
        for (int k = 0; k < 11; k++) tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0011, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0, 0, 0));

        drv(0, 1, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            drv(0, tbl[i].r, tbl[i].b, 16'(tbl[i].c), tbl[i].m, tbl[i].s);
            tick();
            chk("tbl_armed", a0, tbl[i].ea);
            chk("tbl_vote_ok", v0, tbl[i].ev);
            chk("tbl_invalid", i0, tbl[i].ei);
            chk("tbl_count_out", c0, tbl[i].ec);
        end
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        repeat (20) tick();

        // Cancel via mode=1 beats a same-cycle candidate pulse
        drv(0, 0, 1, 0, 0, 0);
        tick();
        chk("cancel_armed_pre", a0, 1);
        drv(0, 0, 0, 16'b1000, 1, 3);
        tick();
        chk("cancel_armed", a0, 0);
        chk("cancel_vote_ok", v0, 0);
        drv(0, 0, 1, 0, 1, 3);
        tick();
        chk("cancel_cnt3", c0, 0);
        chk("ben_mode1_armed", a0, 0);
        drv(0, 0, 0, 0, 0, 0);
        tick();
        chk("ben_mode1_armed2", a0, 0);

        // Reset one cycle into the lockout after three votes
        vote(0, 1);
        vote(0, 2);
        drv(0, 0, 1, 0, 0, 0);
        tick();
        drv(0, 0, 0, 16'b0001, 0, 0);
        tick();
        chk("pre_rst_vote_ok", v0, 1);
        drv(0, 0, 0, 0, 0, 0);
        tick();
        drv(0, 1, 0, 0, 0, 0);
        tick();
        for (int s = 0; s < 4; s++) begin
            drv(0, 0, 0, 0, 1, 2'(s));
            tick();
            chk("rst_cnt_zero", c0, 0);
        end
        drv(0, 0, 1, 0, 0, 0);
        tick();
        chk("rst_rearm", a0, 1);
        drv(0, 0, 0, 16'b0010, 0, 0);
        tick();
        chk("rst_vote_ok", v0, 1);
        drv(0, 0, 0, 0, 0, 0);
        repeat (17) tick();

        // Small instance: five votes for candidate 1 on 2-bit counters
        drv(1, 1, 0, 0, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 0);
        repeat (5) vote(1, 1);
        drv(1, 0, 0, 0, 1, 1);
        tick();
        tick();
        chk("sat_count", c1, SAT_EN ? 3 : 1);
        chk("sat_flag", s1, SAT_EN ? 1 : 0);
        drv(1, 0, 0, 0, 1, 3);
        tick();
        chk("sel_out_of_range", c1, 0);
        drv(1, 0, 0, 0, 0, 0);
        tick();

        for (int unsigned n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                int unsigned r;
                logic [15:0] c;
                r = $urandom_range(0, 3);
                if (r < 2) c = 0;
                else if (r == 2) c = 16'(1) << $urandom_range(0, P_N[d] - 1);
                else c = 16'($urandom) & 16'((1 << P_N[d]) - 1);
                drv(d, $urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, c,
                    $urandom_range(0, 5) == 0, 2'($urandom));
            end
            tick();
        end

        for (int s = 0; s < 4; s++) begin
            drv(0, 0, 0, 0, 1, 2'(s));
            drv(1, 0, 0, 0, 1, 2'(s));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vote_recorder.md
# vote_recorder

Downstream consumer of the per-button edge-detector pulses in the EVM datapath. Arms on a single-cycle ballot-enable pulse from the presiding-officer control, accepts exactly one candidate pulse per ballot, and increments that candidate's vote counter. It then locks out further input for a fixed interval. In result mode it returns the stored count of a selected candidate.

## Interface
- NUM_CAND, 4, number of candidates (2..16)
- CNT_W, 8, width of each vote counter
- LOCK_CYCLES, 16, post-vote lockout length in clk cycles (≥1)
- SEL_W, 2, width of result_sel; must satisfy 2^SEL_W ≥ NUM_CAND

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ballot_en  input  1  one-cycle pulse (edge-detected officer button) arming one ballot
- cand_pulse  input  NUM_CAND  one-cycle pulses from candidate edge detectors, bit i = candidate i
- mode  input  1  0 = voting, 1 = result readout
- result_sel  input  SEL_W  candidate index to read in result mode
- armed  output  1  high while a ballot is open
- vote_ok  output  1  one-cycle pulse: vote recorded
- invalid  output  1  one-cycle pulse: multiple candidate bits in the same cycle while armed
- count_out  output  CNT_W  registered count of candidate result_sel (result mode only)
- sat_flag  output  1  sticky: some counter hit its maximum (see Configuration)

## Operation
- FSM states: IDLE, ARMED, LOCK.
- IDLE: ballot_en=1 and mode=0 → ARMED. cand_pulse ignored. ballot_en while mode=1 ignored.
- ARMED: exactly one cand_pulse bit set → counter[i] += 1, vote_ok pulses, → LOCK. More than one bit set → invalid pulses, no count change, stay ARMED. mode=1 → IDLE (ballot cancelled, no count change); takes priority over a same-cycle cand_pulse. Further ballot_en ignored.
- LOCK: lock counter loaded with LOCK_CYCLES-1 on entry and decremented each cycle. At 0 → IDLE. All inputs are ignored except reset.
- Counters: NUM_CAND × CNT_W. They change only in ARMED on a valid pulse.
- count_out: in mode=1, loaded each cycle with counter[result_sel]. result_sel ≥ NUM_CAND → 0. In mode=0, count_out = 0.
- armed = (state==ARMED), registered.
- Reset: state IDLE, all counters 0, lock counter 0. Outputs armed, vote_ok, invalid, sat_flag are 0, count_out is 0. Reset mid-ARMED or mid-LOCK aborts with no partial count.

## Timing
- ballot_en sampled at edge N → armed=1 after edge N.
- Valid cand_pulse sampled at edge M in ARMED → counter updated, vote_ok=1 and armed=0 after edge M. vote_ok lasts exactly one cycle.
- LOCK occupies exactly LOCK_CYCLES cycles after edge M. ballot_en is accepted again at edge M+LOCK_CYCLES+1 earliest.
- invalid is registered and asserted the cycle after the offending sample.
- count_out latency: 1 cycle from mode/result_sel change. A count updated at edge M is visible on count_out after edge M+1 if in result mode.

## Configuration
- VOTE_REC_SAT_EN defined: a counter at 2^CNT_W-1 holds its value on further votes. sat_flag is set on reaching max and stays set until reset. vote_ok still pulses.
- Undefined: counters wrap modulo 2^CNT_W. sat_flag is tied to 0.

## Test plan
- Reset, then ballot_en, then cand_pulse=4'b0100 → armed 1 then 0, vote_ok one cycle, result mode result_sel=2 → count_out=1, others 0.
- Armed, cand_pulse=4'b0011 → invalid one cycle, counts unchanged, armed stays 1. Then 4'b0001 → counter[0]=1.
- Vote, then ballot_en + cand_pulse during each of the 16 LOCK cycles → no count change. ballot_en on cycle 17 → armed.
- Armed, mode=1 with cand_pulse=4'b1000 in the same cycle → IDLE, counter[3]=0. ballot_en in mode=1 → armed stays 0.
- CNT_W=2, 5 votes for candidate 1 → with VOTE_REC_SAT_EN: count_out=3, sat_flag=1. Without: count_out=1, sat_flag=0.
- Reset asserted one cycle into LOCK after 3 recorded votes → all counts 0, state IDLE, next ballot_en arms normally. result_sel=3 with NUM_CAND=3 → count_out=0.
